// File: rtl/csa_operand_collector.sv
// Collects up to N_OPS operands into a zero-padded frame for the combinational
// adder tree, registers the returned sum and emits it on a valid/ready stream.
module csa_operand_collector #(
   parameter int W     = 8,
   parameter int N_OPS = 6,
   parameter int SW    = 11,
   parameter int CW    = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [W-1:0]       in_data,
   input  logic               in_last,
   output logic [N_OPS*W-1:0] ops_o,
   input  logic [SW-1:0]      sum_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [SW-1:0]      out_sum,
   output logic [CW-1:0]      out_count,
   output logic               busy
);

   localparam logic [1:0] ST_COLLECT = 2'd0;
   localparam logic [1:0] ST_EVAL    = 2'd1;
   localparam logic [1:0] ST_OUTPUT  = 2'd2;

   localparam int IW = (N_OPS > 1) ? $clog2(N_OPS) : 1;

   logic [1:0]         state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [N_OPS*W-1:0] ops_q, ops_d;
   logic [SW-1:0]      sum_q, sum_d;
   logic [CW-1:0]      count_q, count_d;
   logic               accept;

   assign accept = in_valid && in_ready;

   always_comb begin
      // NOTE: every next-state signal takes its hold value first so no path leaves it unassigned (no latches).
      state_d = state_q;
      idx_d   = idx_q;
      ops_d   = ops_q;
      sum_d   = sum_q;
      count_d = count_q;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               ops_d[idx_q*W +: W] = in_data;
               if (idx_q == IW'(N_OPS - 1) || in_last) begin
                  count_d = CW'(idx_q) + CW'(1);
                  idx_d   = '0;
                  state_d = ST_EVAL;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         ST_EVAL: begin
            sum_d   = sum_i;
            state_d = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            // Clearing the slots here is what zero-pads the next short frame.
            if (out_ready) begin
               ops_d   = '0;
               state_d = ST_COLLECT;
            end
         end
         default: state_d = ST_COLLECT;
      endcase
   end

   // NOTE: the operand slots are reset along with the control state, so a frame aborted by reset leaves nothing behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_COLLECT;
         idx_q   <= '0;
         ops_q   <= '0;
         sum_q   <= '0;
         count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the pre-edge values.
         state_q <= state_d;
         idx_q   <= idx_d;
         ops_q   <= ops_d;
         sum_q   <= sum_d;
         count_q <= count_d;
      end
   end

   assign in_ready  = (state_q == ST_COLLECT);
   assign out_valid = (state_q == ST_OUTPUT);
   assign busy      = !((state_q == ST_COLLECT) && (idx_q == '0));
   assign ops_o     = ops_q;
   assign out_sum   = sum_q;
   assign out_count = count_q;

endmodule
